// File: rtl/toy_bus_age_arbiter.sv
// -----------------------------------------------------------------------------
// toy_bus_age_arbiter
//
// Oldest-first arbiter for the toy_bus network. WIDTH requesters use valid/ready
// handshakes and share one registered output slot. An age matrix records the
// arrival order of requests, and the oldest pending request wins. Requests that
// arrive in the same cycle are ordered by index, lowest first, and all of them
// rank behind every request that was already pending. The winner is loaded into
// a 1-entry output stage as a one-hot select plus a binary index.
//
// Ports
//   i_clk      clock, all state on posedge
//   i_rst_n    asynchronous active-low reset
//   i_req_vld  per-requester request valid, held until o_req_rdy
//   o_req_rdy  per-requester accept, one-hot or zero
//   o_out_vld  output slot holds a granted request
//   i_out_rdy  downstream accepts the output slot
//   o_out_sel  one-hot of the granted requester (valid when o_out_vld)
//   o_out_idx  binary index of the granted requester (valid when o_out_vld)
// -----------------------------------------------------------------------------
module toy_bus_age_arbiter #(
    parameter  int WIDTH = 4,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_req_vld,
    output logic [WIDTH-1:0] o_req_rdy,
    output logic             o_out_vld,
    input  logic             i_out_rdy,
    output logic [WIDTH-1:0] o_out_sel,
    output logic [IDX_W-1:0] o_out_idx
);

    localparam int NPAIR = (WIDTH * (WIDTH - 1)) / 2;

    // Only the upper triangle (i<j) of the age matrix is stored. A set bit
    // means requester i is older than requester j; the lower triangle is its
    // complement and the diagonal is constant zero.
    function automatic int pairIdx(input int i, input int j);
        return i * WIDTH - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    logic [NPAIR-1:0] r_age;
    logic [NPAIR-1:0] w_ageNext;
    logic [WIDTH-1:0] r_pend;
    logic [WIDTH-1:0] w_older [WIDTH];
    logic [WIDTH-1:0] w_beats [WIDTH];
    logic [WIDTH-1:0] w_new;
    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] w_fire;
    logic [WIDTH-1:0] w_arr;
    logic [IDX_W-1:0] w_idx;
    logic             w_load;
    logic             w_anyFire;

    // Expand the stored triangle into a full matrix so selection can index
    // any ordered pair directly.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_older[i] = '0;
            for (int j = 0; j < WIDTH; j++) begin
                if (i < j) begin
                    w_older[i][j] = r_age[pairIdx(i, j)];
                end else if (i > j) begin
                    w_older[i][j] = ~r_age[pairIdx(j, i)];
                end
            end
        end
    end

    // A request that is valid but was not pending last cycle is new this cycle,
    // and the matrix does not know about it yet. w_beats[j][i] says whether j
    // outranks i: two pending requests use the matrix, a pending request
    // outranks a new one, and two new requests are ordered by index. A
    // requester is selected when no valid competitor outranks it.
    always_comb begin
        w_new = i_req_vld & ~r_pend;
        for (int j = 0; j < WIDTH; j++) begin
            w_beats[j] = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (i != j) begin
                    if (!w_new[j] && !w_new[i]) begin
                        w_beats[j][i] = w_older[j][i];
                    end else if (!w_new[j] && w_new[i]) begin
                        w_beats[j][i] = 1'b1;
                    end else if (w_new[j] && w_new[i]) begin
                        w_beats[j][i] = (j < i);
                    end else begin
                        w_beats[j][i] = 1'b0;
                    end
                end
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            w_sel[i] = i_req_vld[i];
            for (int j = 0; j < WIDTH; j++) begin
                if (j != i && i_req_vld[j] && w_beats[j][i]) begin
                    w_sel[i] = 1'b0;
                end
            end
        end
    end

    // Encode the one-hot winner into the binary index carried with the grant.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_sel[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    // The slot can take a new grant when it is empty or being drained this
    // cycle. Accepts are suppressed while reset is asserted so that nothing
    // handshakes against state that is being cleared.
    always_comb begin
        w_load    = ~o_out_vld | i_out_rdy;
        o_req_rdy = w_sel & {WIDTH{w_load & i_rst_n}};
        w_fire    = i_req_vld & o_req_rdy;
        w_anyFire = |w_fire;
        w_arr     = i_req_vld & (~r_pend | w_fire);
    end

    // Each arrival becomes the youngest. When both members of a pair arrive
    // together, the lower index is the older one. Pairs that see no arrival
    // keep their bit, which also leaves stale bits behind a withdrawn request
    // until its next arrival overwrites them.
    always_comb begin
        w_ageNext = r_age;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = i + 1; j < WIDTH; j++) begin
                if (w_arr[i] && w_arr[j]) begin
                    w_ageNext[pairIdx(i, j)] = 1'b1;
                end else if (w_arr[i]) begin
                    w_ageNext[pairIdx(i, j)] = 1'b0;
                end else if (w_arr[j]) begin
                    w_ageNext[pairIdx(i, j)] = 1'b1;
                end
            end
        end
    end

    // Age matrix and pending flags. A request that fires is no longer pending,
    // so holding it high afterwards makes it a fresh, youngest arrival.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_age  <= '0;
            r_pend <= '0;
        end else begin
            r_age  <= w_ageNext;
            r_pend <= i_req_vld & ~w_fire;
        end
    end

    // Output slot. A grant loads the slot one cycle after the handshake. A
    // drain without a replacement empties it. While the slot is stalled, its
    // select and index stay unchanged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_out_vld <= 1'b0;
            o_out_sel <= '0;
            o_out_idx <= '0;
        end else if (w_anyFire) begin
            o_out_vld <= 1'b1;
            o_out_sel <= w_sel;
            o_out_idx <= w_idx;
        end else if (i_out_rdy && o_out_vld) begin
            o_out_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_toy_bus_age_arbiter.sv
// -----------------------------------------------------------------------------
// tb_toy_bus_age_arbiter
//
// Directed bench for toy_bus_age_arbiter with WIDTH=4. Each cycle the bench
// drives new inputs shortly after the rising edge. It then checks the
// combinational accept for those inputs and the registered slot left by the
// edge that just passed.
// -----------------------------------------------------------------------------
module tb_toy_bus_age_arbiter;

    localparam int WIDTH = 4;
    localparam int IDX_W = 2;

    logic             clk;
    logic             rstN;
    logic [WIDTH-1:0] reqVld;
    logic [WIDTH-1:0] reqRdy;
    logic             outVld;
    logic             outRdy;
    logic [WIDTH-1:0] outSel;
    logic [IDX_W-1:0] outIdx;

    int checkCount;
    int failCount;

    toy_bus_age_arbiter #(.WIDTH(WIDTH)) dut (
        .i_clk     (clk),
        .i_rst_n   (rstN),
        .i_req_vld (reqVld),
        .o_req_rdy (reqRdy),
        .o_out_vld (outVld),
        .i_out_rdy (outRdy),
        .o_out_sel (outSel),
        .o_out_idx (outIdx)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and count it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock, then drive this cycle's inputs and let them settle.
    task automatic applyStimulus(input logic [WIDTH-1:0] vld, input logic rdy);
        @(posedge clk);
        #1;
        reqVld = vld;
        outRdy = rdy;
        #1;
    endtask

    // Check the registered slot state together with the current accept vector.
    task automatic checkSlot(input string tag, input logic expVld,
                             input logic [IDX_W-1:0] expIdx,
                             input logic [WIDTH-1:0] expRdy);
        checkOutput({tag, ".out_vld"}, 32'(outVld), 32'(expVld));
        if (expVld) begin
            checkOutput({tag, ".out_idx"}, 32'(outIdx), 32'(expIdx));
            checkOutput({tag, ".out_sel"}, 32'(outSel), 32'(1 << expIdx));
        end
        checkOutput({tag, ".req_rdy"}, 32'(reqRdy), 32'(expRdy));
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        rstN   = 1'b0;
        reqVld = '0;
        outRdy = 1'b0;

        // 1: reset state and an idle period.
        #12;
        checkOutput("rst.out_vld", 32'(outVld), 32'd0);
        checkOutput("rst.out_sel", 32'(outSel), 32'd0);
        checkOutput("rst.out_idx", 32'(outIdx), 32'd0);
        checkOutput("rst.req_rdy", 32'(reqRdy), 32'd0);
        rstN = 1'b1;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(4'b0000, 1'b1);
            checkOutput("idle.out_vld", 32'(outVld), 32'd0);
            checkOutput("idle.req_rdy", 32'(reqRdy), 32'd0);
            checkOutput("idle.noX", 32'($isunknown({outVld, outSel, outIdx, reqRdy})), 32'd0);
        end

        // 2: four simultaneous requests drain in index order.
        applyStimulus(4'b1111, 1'b1); checkSlot("t2c0", 1'b0, 2'd0, 4'b0001);
        applyStimulus(4'b1110, 1'b1); checkSlot("t2c1", 1'b1, 2'd0, 4'b0010);
        applyStimulus(4'b1100, 1'b1); checkSlot("t2c2", 1'b1, 2'd1, 4'b0100);
        applyStimulus(4'b1000, 1'b1); checkSlot("t2c3", 1'b1, 2'd2, 4'b1000);
        applyStimulus(4'b0000, 1'b1); checkSlot("t2c4", 1'b1, 2'd3, 4'b0000);
        applyStimulus(4'b0000, 1'b1); checkSlot("t2c5", 1'b0, 2'd0, 4'b0000);

        // 3: arrival order 3,1,0 beats index order.
        applyStimulus(4'b1000, 1'b0); checkSlot("t3c0", 1'b0, 2'd0, 4'b1000);
        applyStimulus(4'b0010, 1'b0); checkSlot("t3c1", 1'b1, 2'd3, 4'b0000);
        applyStimulus(4'b0011, 1'b0); checkSlot("t3c2", 1'b1, 2'd3, 4'b0000);
        applyStimulus(4'b0011, 1'b0); checkSlot("t3c3", 1'b1, 2'd3, 4'b0000);
        applyStimulus(4'b0011, 1'b0); checkSlot("t3c4", 1'b1, 2'd3, 4'b0000);
        applyStimulus(4'b0011, 1'b1); checkSlot("t3c5", 1'b1, 2'd3, 4'b0010);
        applyStimulus(4'b0001, 1'b1); checkSlot("t3c6", 1'b1, 2'd1, 4'b0001);
        applyStimulus(4'b0000, 1'b1); checkSlot("t3c7", 1'b1, 2'd0, 4'b0000);
        applyStimulus(4'b0000, 1'b1); checkSlot("t3c8", 1'b0, 2'd0, 4'b0000);

        // 4: a stalled slot holds steady, then releases back-to-back.
        applyStimulus(4'b0100, 1'b0); checkSlot("t4load", 1'b0, 2'd0, 4'b0100);
        applyStimulus(4'b0000, 1'b0); checkSlot("t4stall0", 1'b1, 2'd2, 4'b0000);
        for (int c = 1; c < 10; c++) begin
            applyStimulus(4'b0001, 1'b0);
            checkSlot("t4stall", 1'b1, 2'd2, 4'b0000);
        end
        applyStimulus(4'b0001, 1'b1); checkSlot("t4rel", 1'b1, 2'd2, 4'b0001);
        applyStimulus(4'b0000, 1'b1); checkSlot("t4next", 1'b1, 2'd0, 4'b0000);
        applyStimulus(4'b0000, 1'b1); checkSlot("t4empty", 1'b0, 2'd0, 4'b0000);

        // 5: req2 held high re-arrives as youngest behind req0.
        applyStimulus(4'b0100, 1'b1); checkSlot("t5c0", 1'b0, 2'd0, 4'b0100);
        applyStimulus(4'b0101, 1'b1); checkSlot("t5c1", 1'b1, 2'd2, 4'b0001);
        applyStimulus(4'b0100, 1'b1); checkSlot("t5c2", 1'b1, 2'd0, 4'b0100);
        applyStimulus(4'b0000, 1'b1); checkSlot("t5c3", 1'b1, 2'd2, 4'b0000);
        applyStimulus(4'b0000, 1'b1); checkSlot("t5c4", 1'b0, 2'd0, 4'b0000);

        // 6: asynchronous reset mid-burst, then ties resolve by index.
        applyStimulus(4'b0001, 1'b0); checkSlot("t6c0", 1'b0, 2'd0, 4'b0001);
        applyStimulus(4'b1110, 1'b0); checkSlot("t6c1", 1'b1, 2'd0, 4'b0000);
        applyStimulus(4'b1110, 1'b0); checkSlot("t6c2", 1'b1, 2'd0, 4'b0000);
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("t6rst.out_vld", 32'(outVld), 32'd0);
        checkOutput("t6rst.out_sel", 32'(outSel), 32'd0);
        checkOutput("t6rst.out_idx", 32'(outIdx), 32'd0);
        checkOutput("t6rst.req_rdy", 32'(reqRdy), 32'd0);
        reqVld = '0;
        @(posedge clk);
        #3;
        rstN = 1'b1;
        applyStimulus(4'b0110, 1'b1); checkSlot("t6c3", 1'b0, 2'd0, 4'b0010);
        applyStimulus(4'b0100, 1'b1); checkSlot("t6c4", 1'b1, 2'd1, 4'b0100);
        applyStimulus(4'b0000, 1'b1); checkSlot("t6c5", 1'b1, 2'd2, 4'b0000);
        applyStimulus(4'b0000, 1'b1); checkSlot("t6c6", 1'b0, 2'd0, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
